// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU sequencer: opcode nibbles,
// data width, state encoding and the illegal-opcode predicate.
package alu_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_AND    = 4'h2,
        OP_OR     = 4'h3,
        OP_XOR    = 4'h4,
        OP_SHL    = 4'h5,
        OP_SHR    = 4'h6,
        OP_MUL_LO = 4'h7,
        OP_MUL_HI = 4'h8,
        OP_INC    = 4'h9,
        OP_DEC    = 4'hA,
        OP_DIV    = 4'hB,
        OP_MOD    = 4'hC,
        OP_CARRY  = 4'hD
    } op_nibble_e;

    localparam logic [3:0] MUL_LO_OP = OP_MUL_LO;
    localparam logic [3:0] MUL_HI_OP = OP_MUL_HI;
    localparam logic [3:0] DIV_OP    = OP_DIV;
    localparam logic [3:0] MOD_OP    = OP_MOD;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE_LO = 2'd1,
        ISSUE_HI = 2'd2,
        DONE     = 2'd3
    } state_e;

    // Nibbles E and F have no ALU function.
    function automatic logic is_illegal_op(input logic [7:0] op);
        return (op[3:0] == 4'hE) || (op[3:0] == 4'hF);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer: issues one op (two for a 16-bit multiply) to the
// external 8-bit ALU, captures its data bus and hands a result to writeback.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W    = alu_pkg::DATA_W,
    parameter logic [3:0]  MUL_LO_OP = alu_pkg::MUL_LO_OP,
    parameter logic [3:0]  MUL_HI_OP = alu_pkg::MUL_HI_OP,
    parameter logic [3:0]  DIV_OP    = alu_pkg::DIV_OP,
    parameter logic [3:0]  MOD_OP    = alu_pkg::MOD_OP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_opcode,
    input  logic [DATA_W-1:0]     in_a,
    input  logic [DATA_W-1:0]     in_b,
    output logic [DATA_W-1:0]     alu_para_a,
    output logic [DATA_W-1:0]     alu_para_b,
    output logic [7:0]            alu_opcode,
    output logic                  alu_en,
    input  logic [DATA_W-1:0]     alu_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W-1:0]   out_result,
    output logic                  out_zero,
    output logic                  out_div0,
    output logic                  out_illegal,
    output logic                  busy
);

    state_e                state_q, state_d;
    logic [DATA_W-1:0]     a_q, a_d;
    logic [DATA_W-1:0]     b_q, b_d;
    logic [7:0]            op_q, op_d;
    logic [7:0]            alu_op_q, alu_op_d;
    logic                  alu_en_q, alu_en_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  zero_q, zero_d;
    logic                  div0_q, div0_d;
    logic                  illegal_q, illegal_d;
    logic                  out_valid_q, out_valid_d;
    logic                  accept;
    logic                  is_divmod;

    assign accept    = in_valid && in_ready;
    assign is_divmod = (op_q[3:0] == DIV_OP) || (op_q[3:0] == MOD_OP);

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        alu_op_d    = alu_op_q;
        alu_en_d    = alu_en_q;
        result_d    = result_q;
        zero_d      = zero_q;
        div0_d      = div0_q;
        illegal_d   = illegal_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d      = in_a;
                    b_d      = in_b;
                    op_d     = in_opcode;
                    alu_op_d = in_opcode;
                    result_d = '0;
                    if (is_illegal_op(in_opcode)) begin
                        state_d     = DONE;
                        illegal_d   = 1'b1;
                        zero_d      = 1'b1;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d  = ISSUE_LO;
                        alu_en_d = 1'b1;
                    end
                end
            end
            ISSUE_LO: begin
                result_d = {{DATA_W{1'b0}}, alu_data};
                if (op_q[3:0] == MUL_LO_OP) begin
                    state_d  = ISSUE_HI;
                    alu_op_d = {op_q[7:4], MUL_HI_OP};
                end else begin
                    state_d     = DONE;
                    alu_en_d    = 1'b0;
                    out_valid_d = 1'b1;
                    zero_d      = (alu_data == '0);
                    div0_d      = is_divmod && (b_q == '0);
                end
            end
            ISSUE_HI: begin
                result_d[2*DATA_W-1:DATA_W] = alu_data;
                state_d     = DONE;
                alu_en_d    = 1'b0;
                out_valid_d = 1'b1;
                zero_d      = ({alu_data, result_q[DATA_W-1:0]} == '0);
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    result_d    = '0;
                    zero_d      = 1'b0;
                    div0_d      = 1'b0;
                    illegal_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            alu_op_q    <= '0;
            alu_en_q    <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            div0_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            alu_op_q    <= alu_op_d;
            alu_en_q    <= alu_en_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            div0_q      <= div0_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = (state_q == IDLE) && rst;
    assign busy        = (state_q != IDLE);
    assign alu_para_a  = a_q;
    assign alu_para_b  = b_q;
    assign alu_opcode  = alu_op_q;
    assign alu_en      = alu_en_q;
    assign out_valid   = out_valid_q;
    assign out_result  = result_q;
    assign out_zero    = zero_q;
    assign out_div0    = div0_q;
    assign out_illegal = illegal_q;

endmodule
